sales_sender: RTL and testbench

SALES_SENDER -- requirements
Module: sales_sender

---
 rtl/sales_sender.sv | 173 +++++++++++++++++
 tb/tb_sales_sender.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sales_sender.sv
// sales_sender: queues (price, num) sales records in a DEPTH-entry FIFO and
// presents them one per cycle on registered outputs to an averaging consumer.
// Records with num == 0 complete their handshake but are dropped.
// Outputs are zeroed on every cycle nothing pops, so each record is counted once.
//
// Optional feature: define SALES_SENDER_CNT_EN to add the sent_cnt[15:0]
// output counting emitted records (wraps at 65535, unaffected by flush).
//
// Handshake: a record transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational from the registered occupancy, flush and rst, and
// never depends on in_valid. Upstream must hold its record stable until taken.
module sales_sender #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_price,
  input  logic [31:0] in_num,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] out_price,
  output logic [31:0] out_num,
  output logic        out_valid,
  output logic        busy,
  output logic [1:0]  dbg_state
`ifdef SALES_SENDER_CNT_EN
  ,
  output logic [15:0] sent_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [63:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [31:0]     r_out_price;
  logic [31:0]     r_out_num;
  logic            r_out_valid;

  logic            w_push;
  logic            w_store;
  logic            w_pop;
  logic            w_busy;

  // Acceptance is blocked in reset, when full, and during a flush request.
  assign in_ready = !rst && (r_count != FULL_CNT) && !flush;
  assign w_push   = in_valid && in_ready;
  // A zero-quantity record is consumed but contributes nothing downstream.
  assign w_store  = w_push && (in_num != 32'd0);
  // Flush wins over a pop in the same cycle, so the popped record is lost too.
  assign w_pop    = (r_state == S_SEND) && !hold && !flush && (r_count != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE means empty, SEND means at least one entry queued.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_store) w_next_state = S_SEND;
        end
        S_SEND: begin
          if (w_pop && !w_store && (r_count == ONE_CNT)) w_next_state = S_IDLE;
        end
        S_FLUSH: begin
          // The queue is empty here; a record taken this cycle starts sending.
          w_next_state = w_store ? S_SEND : S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    w_busy    = (r_state == S_SEND) || (r_state == S_FLUSH);
    dbg_state = r_state;
  end

  assign busy = w_busy;

  // Occupancy and pointers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write; contents are not reset, only pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= {in_price, in_num};
    end
  end

  // Registered output stage: a popped record for one cycle, otherwise all zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_price <= '0;
      r_out_num   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_price <= r_mem[r_rd_ptr][63:32];
      r_out_num   <= r_mem[r_rd_ptr][31:0];
      r_out_valid <= 1'b1;
    end else begin
      r_out_price <= '0;
      r_out_num   <= '0;
      r_out_valid <= 1'b0;
    end
  end

  assign out_price = r_out_price;
  assign out_num   = r_out_num;
  assign out_valid = r_out_valid;

`ifdef SALES_SENDER_CNT_EN
  logic [15:0] r_sent_cnt;

  // Emitted-record counter; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sent_cnt <= '0;
    end else if (w_pop) begin
      r_sent_cnt <= r_sent_cnt + 16'd1;
    end
  end

  assign sent_cnt = r_sent_cnt;
`endif

endmodule

// File: tb/tb_sales_sender.sv
// Directed testbench for sales_sender (DEPTH = 4).
module tb_sales_sender;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_price;
  logic [31:0] in_num;
  logic        hold;
  logic        flush;
  logic [31:0] out_price;
  logic [31:0] out_num;
  logic        out_valid;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef SALES_SENDER_CNT_EN
  logic [15:0] sent_cnt;
`endif

  int n_vec;
  int n_err;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  sales_sender #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_price  (in_price),
    .in_num    (in_num),
    .hold      (hold),
    .flush     (flush),
    .out_price (out_price),
    .out_num   (out_num),
    .out_valid (out_valid),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef SALES_SENDER_CNT_EN
    ,
    .sent_cnt  (sent_cnt)
`endif
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input logic v, input logic [31:0] p, input logic [31:0] n);
    in_valid = v;
    in_price = p;
    in_num   = n;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_rec(1'b1, 32'd5, 32'd5);
    hold = 1'b0;
    flush = 1'b0;
    #2;
    tick;
    tick;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_vec++;
    if ({out_valid, out_price, out_num} !== 65'd0) begin
      n_err++; $display("FAIL reset_outputs: got v=%b p=%0d n=%0d expected all 0", out_valid, out_price, out_num);
    end
    n_vec++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got busy=%b st=%0d expected busy=0 st=0", busy, dbg_state);
    end
    drive_rec(1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [31:0] bp [3];
    logic [31:0] bn [3];
    bp[0] = 32'd1; bn[0] = 32'd2;
    bp[1] = 32'd2; bn[1] = 32'd1;
    bp[2] = 32'd3; bn[2] = 32'd3;
    for (int i = 0; i < 3; i++) begin
      drive_rec(1'b1, bp[i], bn[i]);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL basic_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick;
      n_vec++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL basic_latency: got valid=%b expected 0", out_valid);
        end
      end else if ({out_valid, out_price, out_num} !== {1'b1, bp[i-1], bn[i-1]}) begin
        n_err++; $display("FAIL basic_out[%0d]: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                          i-1, out_valid, out_price, out_num, bp[i-1], bn[i-1]);
      end
    end
    drive_rec(1'b0, 32'd0, 32'd0);
    tick;
    n_vec++;
    if ({out_valid, out_price, out_num} !== {1'b1, 32'd3, 32'd3}) begin
      n_err++; $display("FAIL basic_out[2]: got v=%b (%0d,%0d) expected v=1 (3,3)", out_valid, out_price, out_num);
    end
    tick;
    n_vec++;
    if ({out_valid, out_price, out_num, busy} !== 66'd0) begin
      n_err++; $display("FAIL basic_drain: got v=%b (%0d,%0d) busy=%b expected all 0", out_valid, out_price, out_num, busy);
    end
  endtask

  task automatic test_hold_full;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rec(1'b1, 32'd100 + 32'(i), 32'd10 + 32'(i));
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL hold_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick;
    end
    drive_rec(1'b1, 32'd104, 32'd14);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL hold_full_ready: got %b expected 0", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_no_pop: got valid=%b expected 0", out_valid);
    end
    tick;
    tick;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_stall: got ready=%b valid=%b expected 0 0", in_ready, out_valid);
    end
    hold = 1'b0;
    tick;
    n_vec++;
    if ({out_valid, out_price, out_num} !== {1'b1, 32'd100, 32'd10}) begin
      n_err++; $display("FAIL hold_pop0: got v=%b (%0d,%0d) expected v=1 (100,10)", out_valid, out_price, out_num);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL hold_reopen: got %b expected 1", in_ready);
    end
    tick;
    drive_rec(1'b0, 32'd0, 32'd0);
    n_vec++;
    if ({out_valid, out_price, out_num} !== {1'b1, 32'd101, 32'd11}) begin
      n_err++; $display("FAIL hold_pop1: got v=%b (%0d,%0d) expected v=1 (101,11)", out_valid, out_price, out_num);
    end
    for (int k = 2; k < 5; k++) begin
      tick;
      n_vec++;
      if ({out_valid, out_price, out_num} !== {1'b1, 32'd100 + 32'(k), 32'd10 + 32'(k)}) begin
        n_err++; $display("FAIL hold_pop%0d: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                          k, out_valid, out_price, out_num, 100 + k, 10 + k);
      end
    end
    tick;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL hold_drain: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_zero_num;
    drive_rec(1'b1, 32'd7, 32'd0);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_ready: got %b expected 1", in_ready);
    end
    tick;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_dropped: got busy=%b valid=%b expected 0 0", busy, out_valid);
    end
    drive_rec(1'b1, 32'd4, 32'd5);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL zero_ready2: got %b expected 1", in_ready);
    end
    tick;
    drive_rec(1'b0, 32'd0, 32'd0);
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_queued: got busy=%b valid=%b expected 1 0", busy, out_valid);
    end
    tick;
    n_vec++;
    if ({out_valid, out_price, out_num} !== {1'b1, 32'd4, 32'd5}) begin
      n_err++; $display("FAIL zero_emit: got v=%b (%0d,%0d) expected v=1 (4,5)", out_valid, out_price, out_num);
    end
    tick;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_only_one: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rec(1'b1, 32'd200 + 32'(i), 32'd1);
      tick;
    end
    drive_rec(1'b1, 32'd9, 32'd9);
    flush = 1'b1;
    hold = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_ready: got %b expected 0", in_ready);
    end
    tick;
    flush = 1'b0;
    drive_rec(1'b0, 32'd0, 32'd0);
    n_vec++;
    if (busy !== 1'b1 || dbg_state !== ST_FLUSH || out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_state: got busy=%b st=%0d valid=%b expected 1 2 0", busy, dbg_state, out_valid);
    end
    tick;
    n_vec++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_idle: got busy=%b st=%0d valid=%b ready=%b expected 0 0 0 1",
                        busy, dbg_state, out_valid, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_no_emit[%0d]: got valid=%b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rec(1'b1, 32'd300 + 32'(i), 32'd1 + 32'(i));
      tick;
    end
    drive_rec(1'b0, 32'd0, 32'd0);
    hold = 1'b0;
    tick;
    n_vec++;
    if ({out_valid, out_price, out_num} !== {1'b1, 32'd300, 32'd1}) begin
      n_err++; $display("FAIL rstmid_pop0: got v=%b (%0d,%0d) expected v=1 (300,1)", out_valid, out_price, out_num);
    end
    tick;
    n_vec++;
    if ({out_valid, out_price, out_num} !== {1'b1, 32'd301, 32'd2}) begin
      n_err++; $display("FAIL rstmid_pop1: got v=%b (%0d,%0d) expected v=1 (301,2)", out_valid, out_price, out_num);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, out_price, out_num, busy, in_ready} !== 67'd0) begin
      n_err++; $display("FAIL rstmid_async: got v=%b (%0d,%0d) busy=%b ready=%b expected all 0",
                        out_valid, out_price, out_num, busy, in_ready);
    end
    tick;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rstmid_quiet[%0d]: got valid=%b busy=%b expected 0 0", k, out_valid, busy);
      end
    end
  endtask

`ifdef SALES_SENDER_CNT_EN
  task automatic test_sent_cnt;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    n_vec++;
    if (sent_cnt !== 16'd0) begin
      n_err++; $display("FAIL cnt_reset: got %0d expected 0", sent_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive_rec(1'b1, 32'd50 + 32'(i), 32'd2);
      tick;
    end
    drive_rec(1'b0, 32'd0, 32'd0);
    tick;
    tick;
    n_vec++;
    if (sent_cnt !== 16'd3) begin
      n_err++; $display("FAIL cnt_three: got %0d expected 3", sent_cnt);
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
    n_vec++;
    if (sent_cnt !== 16'd3) begin
      n_err++; $display("FAIL cnt_flush: got %0d expected 3", sent_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive_rec(1'b1, 32'd60 + 32'(i), 32'd3);
      tick;
    end
    drive_rec(1'b0, 32'd0, 32'd0);
    tick;
    tick;
    n_vec++;
    if (sent_cnt !== 16'd5) begin
      n_err++; $display("FAIL cnt_five: got %0d expected 5", sent_cnt);
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    hold = 1'b0;
    flush = 1'b0;
    drive_rec(1'b0, 32'd0, 32'd0);
    test_reset;
    test_basic;
    test_hold_full;
    test_zero_num;
    test_flush;
    test_reset_mid;
`ifdef SALES_SENDER_CNT_EN
    test_sent_cnt;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
